// File: rtl/mux_scan_serializer.sv
// Serializes a 16-bit word through an external Mux16to1: this block drives the mux data and
// select, and passes the returned mux output on as a valid/ready serial stream.
module mux_scan_serializer #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        Clock,
   input  logic        ResetN,
   input  logic        LoadValid,
   input  logic [15:0] LoadData,
   output logic        LoadReady,
   output logic [15:0] DataArray,
   output logic [3:0]  Select,
   input  logic        MuxOut,
   output logic        SerValid,
   output logic        SerData,
   input  logic        SerReady,
   output logic        SerLast,
   input  logic        Abort,
   output logic        Done
);

   typedef enum logic {Idle, Shift} stateE;

   stateE      state;
   logic [3:0] cnt;
   logic       isShift;
   logic       loadFire;
   logic       beat;

   always_comb begin
      isShift   = (state == Shift);
      SerValid  = isShift;
      SerData   = MuxOut;
      SerLast   = isShift && (cnt == 4'd15);
      // Abort blocks a reload on the final beat; in Idle it has no effect.
      LoadReady = !isShift || (SerLast && SerReady && !Abort);
      loadFire  = LoadValid && LoadReady;
      beat      = isShift && SerReady && !Abort;
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state     <= Idle;
         cnt       <= 4'd0;
         DataArray <= 16'h0000;
         Select    <= 4'd0;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (isShift && Abort) begin
            state <= Idle;
         end else begin
            if (beat) begin
               if (SerLast) begin
                  Done  <= 1'b1;
                  state <= Idle;
               end else begin
                  cnt    <= cnt + 4'd1;
                  Select <= LSB_FIRST ? Select + 4'd1 : Select - 4'd1;
               end
            end
            // A load on the final beat overrides the return to Idle.
            if (loadFire) begin
               DataArray <= LoadData;
               Select    <= LSB_FIRST ? 4'd0 : 4'd15;
               cnt       <= 4'd0;
               state     <= Shift;
            end
         end
      end
   end

endmodule
